// File: rtl/tinyml_axi_rd_scheduler.sv
// Round-robin AXI AR scheduler: tracks in-flight bursts in an owner FIFO and steers R beats back to requesters.
// Optional macro TINYML_AXI_RD_SCHEDULER_ERR_EN: accept/drop orphan R beats and raise a sticky err flag.
module tinyml_axi_rd_scheduler #(
  parameter int PORTS           = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PORTS-1:0]                   s_arvalid,
  input  logic [PORTS*ADDR_WIDTH-1:0]        s_araddr,
  input  logic [PORTS*8-1:0]                 s_arlen,
  output logic [PORTS-1:0]                   s_arready,
  output logic                               m_arvalid,
  output logic [ADDR_WIDTH-1:0]              m_araddr,
  output logic [7:0]                         m_arlen,
  input  logic                               m_arready,
  input  logic                               m_rvalid,
  input  logic                               m_rlast,
  output logic                               m_rready,
  output logic [PORTS-1:0]                   s_rvalid,
  input  logic [PORTS-1:0]                   s_rready,
  output logic [$clog2(PORTS)-1:0]           r_port,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err
);
  localparam int IW = $clog2(PORTS);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic {ARB, ISSUE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_arr [PORTS];
  logic [7:0]            len_arr  [PORTS];
  logic [IW-1:0]         rr_ptr, winner, grant_idx, head;
  logic                  grant_found, start, push, pop, has_out;
  logic [IW-1:0]         fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  for (genvar g = 0; g < PORTS; g++) begin : g_unpack
    assign addr_arr[g] = s_araddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[g]  = s_arlen[g*8 +: 8];
  end

  // Scan from the highest rotated rank down so the lowest rank at/after rr_ptr wins.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= PORTS) idx = idx - PORTS;
      if (s_arvalid[IW'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  assign start   = (state == ARB) && grant_found && (count < CW'(MAX_OUTSTANDING));
  assign has_out = (count != '0);
  assign head    = fifo_mem[rd_ptr];
  assign pop     = has_out && m_rvalid && m_rready && m_rlast;
  assign outstanding = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      rr_ptr   <= '0;
      winner   <= '0;
      m_araddr <= '0;
      m_arlen  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        winner   <= grant_idx;
        m_araddr <= addr_arr[grant_idx];
        m_arlen  <= len_arr[grant_idx];
        rr_ptr   <= (grant_idx == IW'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    s_arready = '0;
    m_arvalid = 1'b0;
    push      = 1'b0;
    case (state)
      ARB: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          s_arready[winner] = 1'b1;
          push              = 1'b1;
          state_nxt         = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    s_rvalid = '0;
    r_port   = '0;
    m_rready = 1'b0;
    if (has_out) begin
      s_rvalid[head] = m_rvalid;
      m_rready       = s_rready[head];
      r_port         = head;
    end else begin
`ifdef TINYML_AXI_RD_SCHEDULER_ERR_EN
      m_rready = !rst;
`else
      m_rready = 1'b0;
`endif
    end
  end

`ifdef TINYML_AXI_RD_SCHEDULER_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        err <= 1'b0;
    else if (m_rvalid && !has_out)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/tinyml_axi_rd_scheduler.md
TINYML_AXI_RD_SCHEDULER -- requirements
Module: tinyml_axi_rd_scheduler

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of requesters, range 2..16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AR address width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4: depth of the in-flight burst tracking FIFO, power of two, range 2..16.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port s_arvalid, input, PORTS: per-requester read-address valid.
REQ-007 SHALL have port s_araddr, input, PORTS*ADDR_WIDTH: per-requester address; port i in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port s_arlen, input, PORTS*8: per-requester AXI burst length; port i in slice [i*8 +: 8].
REQ-009 SHALL have port s_arready, output, PORTS: per-requester address accept.
REQ-010 SHALL have the following downstream AR ports: m_arvalid (output, 1); m_araddr (output, ADDR_WIDTH); m_arlen (output, 8); m_arready (input, 1).
REQ-011 SHALL have the following downstream R ports: m_rvalid (input, 1); m_rlast (input, 1); m_rready (output, 1).
REQ-012 SHALL have port s_rvalid, output, PORTS: per-requester R valid.
REQ-013 SHALL have port s_rready, input, PORTS: per-requester R ready.
REQ-014 SHALL have port r_port, output, $clog2(PORTS): encoded owner of the current R beat, used to steer the external data mux.
REQ-015 SHALL have port outstanding, output, $clog2(MAX_OUTSTANDING)+1: number of bursts in flight.
REQ-016 SHALL have port err, output, 1: unexpected-response flag.

Function
REQ-017 SHALL implement a two-state FSM.
- States are ARB and ISSUE.
- In ARB, when any s_arvalid is set and outstanding<MAX_OUTSTANDING, it SHALL register the winner index and address/len, then move to ISSUE.
REQ-018 SHALL arbitrate round-robin with LSB-low rotation.
- After a grant to index k, the search starts at k+1 and wraps to 0.
- After reset, the search starts at index 0.
REQ-019 SHALL drive m_arvalid=1 in ISSUE with registered m_araddr/m_arlen.
- These values SHALL be held stable until m_arready.
- On the handshake, s_arready[winner] SHALL pulse 1 for that same cycle and the FSM SHALL return to ARB.
- Minimum issue rate is one AR every 2 cycles.
REQ-020 SHALL hold s_arready low for every port except the winner during an ISSUE handshake cycle.
REQ-021 SHALL push the winner index into the tracking FIFO on each AR handshake.
REQ-022 SHALL route R beats by the FIFO head when outstanding>0:
- s_rvalid[head]=m_rvalid;
- m_rready=s_rready[head];
- r_port=head;
- all other s_rvalid bits=0.
REQ-023 SHALL pop the FIFO on the cycle m_rvalid, m_rready and m_rlast are all 1.
REQ-024 SHALL leave outstanding unchanged when a push and a pop occur in the same cycle.
REQ-025 SHALL not arbitrate while outstanding==MAX_OUTSTANDING.
- Arbitration resumes in the cycle after a pop.
REQ-026 SHALL drive s_rvalid=0 and r_port=0 when outstanding==0.
REQ-027 SHALL not re-arbitrate in ISSUE, even if higher-ranked requesters assert s_arvalid.

Reset
REQ-028 SHALL, while rst=1 (asynchronously), force the following state:
- FSM=ARB, round-robin pointer=0;
- FIFO empty, outstanding=0;
- m_arvalid=0, m_araddr=0, m_arlen=0;
- s_arready=0, s_rvalid=0, m_rready=0;
- r_port=0, err=0.
REQ-029 SHALL discard any in-flight AR or tracked bursts when rst is asserted mid-operation; no beats are routed afterward.

Configuration
REQ-030 SHALL use macro TINYML_AXI_RD_SCHEDULER_ERR_EN to control handling of unexpected responses.
- Defined: m_rvalid with outstanding==0 is accepted (m_rready=1) and dropped, and err is set sticky until reset.
- Undefined: err is tied 0, and m_rready=0 when outstanding==0.

Verification
REQ-031 SHALL cover this scenario: s_arvalid=4'b1111 held, m_arready=1, every burst completes.
- Required response: grants in order 0,1,2,3,0, with one AR every 2 cycles.
REQ-032 SHALL cover this scenario: port 2 requests addr 0x1000 len 3, with m_arready low 5 cycles.
- Required response: m_araddr=0x1000, m_arlen=3 held stable; s_arready[2] pulses exactly once.
REQ-033 SHALL cover this scenario (MAX_OUTSTANDING=4): 4 bursts issued with no R beats.
- Required response: outstanding=4, and a 5th request gets no AR until the first m_rlast handshake.
REQ-034 SHALL cover this scenario: bursts issued for ports 1 then 3, then R beats len+1 each.
- Required response: beats go to s_rvalid[1] and then [3]; r_port=1 then 3; outstanding 2->1->0.
REQ-035 SHALL cover this scenario: an AR handshake and an m_rlast pop in the same cycle.
- Required response: outstanding unchanged.
REQ-036 SHALL cover this scenario: m_rvalid=1 with outstanding=0.
- Required response: with TINYML_AXI_RD_SCHEDULER_ERR_EN, m_rready=1 and err=1 sticky; without it, m_rready=0 and err=0.
